mips_mc_ctrl: RTL

Multi-cycle control sequencer for the MIPS datapath. It drives the enables of the datapath's enabled D-registers (PC, IR, MDR, A/B, ALUOut) and the memory, register-file and mux selects, one instruction at a time, through a Moore state machine. It sits beside the datapath and replaces the single-cycle combinational decoder when the core is built multi-cycle. An optional memory-wait handshake lets instruction and data accesses stretch over several cycles.

---
 rtl/mips_mc_pkg.sv | 40 ++++
 rtl/mips_mc_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multi-cycle MIPS control sequencer: state codes,
// opcodes and the mux/ALU select encodings driven onto the datapath.
package mips_mc_pkg;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_MEMADR = 4'd2,
        ST_MEMRD  = 4'd3,
        ST_MEMWB  = 4'd4,
        ST_MEMWR  = 4'd5,
        ST_EXEC   = 4'd6,
        ST_ALUWB  = 4'd7,
        ST_BRANCH = 4'd8,
        ST_ADDIEX = 4'd9,
        ST_ADDIWB = 4'd10,
        ST_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_mc_ctrl.sv
// Moore control sequencer for the multi-cycle MIPS datapath.
// Optional memory-wait handshake on FETCH/MEMRD/MEMWR: define MC_CTRL_MEM_WAIT_EN.
module mips_mc_ctrl
    import mips_mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       ir_en,
    output logic       mdr_en,
    output logic       ab_en,
    output logic       aluout_en,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       iord,
    output logic       rf_we,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic [3:0] state
);

    state_t state_q, state_d;
    logic   run;
    logic   mem_done;

`ifdef MC_CTRL_MEM_WAIT_EN
    assign mem_done = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_done         = 1'b1;
`endif

    // run holds the machine idle until the first edge after reset release,
    // so that edge begins a full FETCH cycle rather than leaving it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_FETCH;
            run     <= 1'b0;
        end else begin
            state_q <= state_d;
            run     <= 1'b1;
        end
    end

    assign state = state_q;

    always_comb begin
        state_d = state_q;
        if (run) begin
            case (state_q)
                ST_FETCH:  if (mem_done) state_d = ST_DECODE;
                ST_DECODE: begin
                    case (op)
                        OP_LW, OP_SW: state_d = ST_MEMADR;
                        OP_RTYPE:     state_d = ST_EXEC;
                        OP_BEQ:       state_d = ST_BRANCH;
                        OP_ADDI:      state_d = ST_ADDIEX;
                        OP_J:         state_d = ST_JUMP;
                        default:      state_d = ST_FETCH;
                    endcase
                end
                ST_MEMADR: state_d = (op == OP_SW) ? ST_MEMWR : ST_MEMRD;
                ST_MEMRD:  if (mem_done) state_d = ST_MEMWB;
                ST_MEMWB:  state_d = ST_FETCH;
                ST_MEMWR:  if (mem_done) state_d = ST_FETCH;
                ST_EXEC:   state_d = ST_ALUWB;
                ST_ALUWB:  state_d = ST_FETCH;
                ST_BRANCH: state_d = ST_FETCH;
                ST_ADDIEX: state_d = ST_ADDIWB;
                ST_ADDIWB: state_d = ST_FETCH;
                ST_JUMP:   state_d = ST_FETCH;
                default:   state_d = ST_FETCH;
            endcase
        end
    end

    // Everything is forced low while idle, so an asserted reset kills all writes at once.
    always_comb begin
        pc_en      = 1'b0;
        ir_en      = 1'b0;
        mdr_en     = 1'b0;
        ab_en      = 1'b0;
        aluout_en  = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        iord       = 1'b0;
        rf_we      = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_B;
        alu_op     = ALU_ADD;
        pc_src     = PC_ALU;
        if (run) begin
            case (state_q)
                ST_FETCH: begin
                    mem_rd    = 1'b1;
                    ir_en     = mem_done;
                    pc_en     = mem_done;
                    alu_src_b = SRCB_FOUR;
                end
                ST_DECODE: begin
                    ab_en     = 1'b1;
                    aluout_en = 1'b1;
                    alu_src_b = SRCB_IMM_SH2;
                end
                ST_MEMADR, ST_ADDIEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    aluout_en = 1'b1;
                end
                ST_MEMRD: begin
                    mem_rd = 1'b1;
                    iord   = 1'b1;
                    mdr_en = mem_done;
                end
                ST_MEMWB: begin
                    rf_we      = 1'b1;
                    mem_to_reg = 1'b1;
                end
                ST_MEMWR: begin
                    mem_wr = 1'b1;
                    iord   = 1'b1;
                end
                ST_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_FUNCT;
                    aluout_en = 1'b1;
                end
                ST_ALUWB: begin
                    rf_we   = 1'b1;
                    reg_dst = 1'b1;
                end
                ST_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_SUB;
                    pc_src    = PC_ALUOUT;
                    pc_en     = zero;
                end
                ST_ADDIWB: rf_we = 1'b1;
                ST_JUMP: begin
                    pc_src = PC_JUMP;
                    pc_en  = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
